// File: rtl/time_set_controller_pkg.sv
// Shared definitions for the time-setting controller.
//   - FSM state encodings (also reused as the mode LED pattern for set states)
//   - hour/minute limits and the per-digit blanking masks
//   - wrap-around increment/decrement helpers for the edit registers
package time_set_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_SET_HOURS   = 2'd1,
    ST_SET_MINUTES = 2'd2,
    ST_COMMIT      = 2'd3
  } state_e;

  localparam logic [5:0] HOURS_MAX     = 6'd23;
  localparam logic [5:0] MINUTES_MAX   = 6'd59;

  localparam logic [3:0] BLANK_HOURS   = 4'b1100;
  localparam logic [3:0] BLANK_MINUTES = 4'b0011;

  // Values above max (possible from a live capture) step up to 0.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_v);
    return (v >= max_v) ? 6'd0 : v + 6'd1;
  endfunction

  // Values above max step down to max.
  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max_v);
    return ((v == 6'd0) || (v > max_v)) ? max_v : v - 6'd1;
  endfunction

endpackage

// File: rtl/time_set_controller_key_debounce.sv
// Key conditioning for one active-low pushbutton.
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   key_n_i  raw button level, asynchronous, low = pressed
//   pulse_o  one-cycle pulse on an accepted press, plus auto-repeat steps
//            while held when REPEAT_EN is set
// pulse_o is combinational from registered state, so the consumer acts on
// the same edge at which the debounced level flips (latency DEBOUNCE_CYCLES+2).
module time_set_controller_key_debounce #(
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES = 25_000_000,
  parameter int REPEAT_RATE_CYCLES  = 5_000_000,
  parameter bit REPEAT_EN           = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic pulse_o
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;     // 1 = accepted pressed
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             pressed_s;
  logic             press;
  logic             rep_fire;

  assign pressed_s = ~sync2_q;

  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    press    = 1'b0;
    if (pressed_s != level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = pressed_s;
        press   = pressed_s;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Repeat timer runs only while both the accepted and the synchronized
  // levels say pressed, so a release cancels repeats without waiting for
  // the debounce window.
  always_comb begin
    rep_cnt_d = '0;
    rep_fire  = 1'b0;
    if (press) begin
      rep_cnt_d = REP_W'(REPEAT_DELAY_CYCLES - 1);
    end else if (level_q && pressed_s) begin
      if (rep_cnt_q == '0) begin
        rep_fire  = REPEAT_EN;
        rep_cnt_d = REP_W'(REPEAT_RATE_CYCLES - 1);
      end else begin
        rep_cnt_d = rep_cnt_q - REP_W'(1);
      end
    end
  end

  assign pulse_o = press | rep_fire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      level_q   <= 1'b0;
      db_cnt_q  <= '0;
      rep_cnt_q <= '0;
    end else begin
      sync1_q   <= key_n_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// User time-setting sequencer between the board keys, TimeOfDay and TimeTo7Seg.
//   CLOCK_50       system clock
//   RESET_N        asynchronous active-low reset
//   key_*_n        raw mode/up/down buttons, low = pressed
//   cur_hours/min  live time from TimeOfDay
//   run_en         TimeOfDay count enable (low while editing)
//   load           one-cycle commit strobe with load_hours/load_minutes
//   disp_hours/min time shown on the display (live or edit values)
//   blank_hex      per-digit blanking, bit i blanks HEXi
//   mode_led       00 run, 01 setting hours, 10 setting minutes
//
// state          | meaning
// ST_RUN         | clock counting, display shows live time
// ST_SET_HOURS   | counting paused, up/down edit hours, hour digits blink
// ST_SET_MINUTES | counting paused, up/down edit minutes, minute digits blink
// ST_COMMIT      | single cycle: load strobe with the edited time
module time_set_controller
  import time_set_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES = 25_000_000,
  parameter int REPEAT_RATE_CYCLES  = 5_000_000,
  parameter int BLINK_CYCLES        = 12_500_000,
  parameter int TIMEOUT_CYCLES      = 500_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       key_mode_n,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_hours,
  output logic       run_en,
  output logic       load,
  output logic [5:0] load_minutes,
  output logic [5:0] load_hours,
  output logic [5:0] disp_minutes,
  output logic [5:0] disp_hours,
  output logic [3:0] blank_hex,
  output logic [1:0] mode_led
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic mode_p, up_p, down_p;

  time_set_controller_key_debounce #(
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
    .REPEAT_EN          (1'b0)
  ) u_key_mode (
    .clk_i  (CLOCK_50),
    .rst_ni (RESET_N),
    .key_n_i(key_mode_n),
    .pulse_o(mode_p)
  );

  time_set_controller_key_debounce #(
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
    .REPEAT_EN          (1'b1)
  ) u_key_up (
    .clk_i  (CLOCK_50),
    .rst_ni (RESET_N),
    .key_n_i(key_up_n),
    .pulse_o(up_p)
  );

  time_set_controller_key_debounce #(
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
    .REPEAT_EN          (1'b1)
  ) u_key_down (
    .clk_i  (CLOCK_50),
    .rst_ni (RESET_N),
    .key_n_i(key_down_n),
    .pulse_o(down_p)
  );

  state_e          state_q, state_d;
  logic [5:0]      edit_h_q, edit_h_d;
  logic [5:0]      edit_m_q, edit_m_d;
  logic [5:0]      load_h_q, load_h_d;
  logic [5:0]      load_m_q, load_m_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;

  logic any_p, up_only, down_only;
  logic enter_set, step_applied;

  assign any_p     = mode_p | up_p | down_p;
  assign up_only   = up_p & ~down_p;
  assign down_only = down_p & ~up_p;

  always_comb begin
    state_d      = state_q;
    edit_h_d     = edit_h_q;
    edit_m_d     = edit_m_q;
    load_h_d     = load_h_q;
    load_m_d     = load_m_q;
    enter_set    = 1'b0;
    step_applied = 1'b0;

    // Mode is checked first so a coincident step is dropped; a timeout only
    // fires on a cycle with no key pulse because any pulse restarts it.
    case (state_q)
      ST_RUN: begin
        if (mode_p) begin
          state_d   = ST_SET_HOURS;
          edit_h_d  = cur_hours;
          edit_m_d  = cur_minutes;
          enter_set = 1'b1;
        end
      end
      ST_SET_HOURS: begin
        if (mode_p) begin
          state_d   = ST_SET_MINUTES;
          enter_set = 1'b1;
        end else if (up_only) begin
          edit_h_d     = wrap_inc(edit_h_q, HOURS_MAX);
          step_applied = 1'b1;
        end else if (down_only) begin
          edit_h_d     = wrap_dec(edit_h_q, HOURS_MAX);
          step_applied = 1'b1;
        end else if (!any_p && (to_cnt_q == '0)) begin
          state_d = ST_RUN;
        end
      end
      ST_SET_MINUTES: begin
        if (mode_p) begin
          state_d  = ST_COMMIT;
          load_h_d = edit_h_q;
          load_m_d = edit_m_q;
        end else if (up_only) begin
          edit_m_d     = wrap_inc(edit_m_q, MINUTES_MAX);
          step_applied = 1'b1;
        end else if (down_only) begin
          edit_m_d     = wrap_dec(edit_m_q, MINUTES_MAX);
          step_applied = 1'b1;
        end else if (!any_p && (to_cnt_q == '0)) begin
          state_d = ST_RUN;
        end
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase

    if (enter_set || any_p) begin
      to_cnt_d = TO_W'(TIMEOUT_CYCLES - 1);
    end else if (to_cnt_q != '0) begin
      to_cnt_d = to_cnt_q - TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end

    if (enter_set || step_applied) begin
      blink_cnt_d = BL_W'(BLINK_CYCLES - 1);
      phase_d     = 1'b0;
    end else if (blink_cnt_q == '0) begin
      blink_cnt_d = BL_W'(BLINK_CYCLES - 1);
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q - BL_W'(1);
      phase_d     = phase_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_RUN;
      edit_h_q    <= '0;
      edit_m_q    <= '0;
      load_h_q    <= '0;
      load_m_q    <= '0;
      to_cnt_q    <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      edit_h_q    <= edit_h_d;
      edit_m_q    <= edit_m_d;
      load_h_q    <= load_h_d;
      load_m_q    <= load_m_d;
      to_cnt_q    <= to_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign run_en       = (state_q == ST_RUN);
  assign load         = (state_q == ST_COMMIT);
  assign load_hours   = load_h_q;
  assign load_minutes = load_m_q;
  assign disp_hours   = (state_q == ST_RUN) ? cur_hours   : edit_h_q;
  assign disp_minutes = (state_q == ST_RUN) ? cur_minutes : edit_m_q;

  always_comb begin
    mode_led  = 2'b00;
    blank_hex = 4'b0000;
    if (state_q == ST_SET_HOURS) begin
      mode_led = 2'b01;
      if (phase_q) blank_hex = BLANK_HOURS;
    end else if (state_q == ST_SET_MINUTES) begin
      mode_led = 2'b10;
      if (phase_q) blank_hex = BLANK_MINUTES;
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
module tb_time_set_controller;
  import time_set_controller_pkg::*;

  typedef struct packed {
    logic [5:0] h;
    logic [5:0] m;
  } hm_t;

  logic       CLOCK_50   = 1'b0;
  logic       RESET_N    = 1'b0;
  logic       key_mode_n = 1'b1;
  logic       key_up_n   = 1'b1;
  logic       key_down_n = 1'b1;
  logic [5:0] cur_minutes = 6'd0;
  logic [5:0] cur_hours   = 6'd0;
  logic       run_en, load;
  logic [5:0] load_minutes, load_hours, disp_minutes, disp_hours;
  logic [3:0] blank_hex;
  logic [1:0] mode_led;

  int n_tests = 0;
  int n_fail  = 0;

  hm_t disp_exp[$];
  hm_t load_exp[$];
  hm_t prev_disp = '0;
  logic [1:0] prev_led = 2'b00;

  always #5 CLOCK_50 = ~CLOCK_50;

  time_set_controller #(
    .DEBOUNCE_CYCLES    (4),
    .REPEAT_DELAY_CYCLES(20),
    .REPEAT_RATE_CYCLES (5),
    .BLINK_CYCLES       (8),
    .TIMEOUT_CYCLES     (200)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .key_mode_n  (key_mode_n),
    .key_up_n    (key_up_n),
    .key_down_n  (key_down_n),
    .cur_minutes (cur_minutes),
    .cur_hours   (cur_hours),
    .run_en      (run_en),
    .load        (load),
    .load_minutes(load_minutes),
    .load_hours  (load_hours),
    .disp_minutes(disp_minutes),
    .disp_hours  (disp_hours),
    .blank_hex   (blank_hex),
    .mode_led    (mode_led)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // which: 0 mode, 1 up, 2 down, 3 up+down together
  task automatic press(input int which, input int hold);
    if (which == 0) key_mode_n = 1'b0;
    if (which == 1 || which == 3) key_up_n = 1'b0;
    if (which == 2 || which == 3) key_down_n = 1'b0;
    repeat (hold) tick();
    key_mode_n = 1'b1;
    key_up_n   = 1'b1;
    key_down_n = 1'b1;
    repeat (8) tick();
  endtask

  task automatic set_cur(input logic [5:0] h, input logic [5:0] m);
    cur_hours   = h;
    cur_minutes = m;
  endtask

  // Scoreboard consumers: edits in a set state and commit strobes.
  always @(negedge CLOCK_50) begin
    hm_t now_d;
    hm_t e;
    now_d = {disp_hours, disp_minutes};
    if (RESET_N && mode_led != 2'b00 && mode_led == prev_led && now_d != prev_disp) begin
      if (disp_exp.size() > 0) begin
        e = disp_exp.pop_front();
        check("disp_step", 32'(now_d), 32'(e));
      end else begin
        check("disp_unexpected", 32'(now_d), 32'(prev_disp));
      end
    end
    if (RESET_N && load) begin
      if (load_exp.size() > 0) begin
        e = load_exp.pop_front();
        check("load_val", 32'({load_hours, load_minutes}), 32'(e));
      end else begin
        check("load_unexpected", 32'(load), 32'(0));
      end
    end
    prev_disp <= now_d;
    prev_led  <= mode_led;
  end

  initial begin
    // 1: reset
    set_cur(6'd7, 6'd30);
    repeat (3) tick();
    RESET_N = 1'b1;
    tick();
    check("rst_run_en", 32'(run_en), 32'(1));
    check("rst_load", 32'(load), 32'(0));
    check("rst_blank", 32'(blank_hex), 32'(0));
    check("rst_led", 32'(mode_led), 32'(0));
    check("rst_disp", 32'({disp_hours, disp_minutes}), 32'({6'd7, 6'd30}));

    // 2: glitch rejected, then real press with exact latency
    key_mode_n = 1'b0;
    repeat (3) tick();
    key_mode_n = 1'b1;
    repeat (10) tick();
    check("glitch_led", 32'(mode_led), 32'(0));
    key_mode_n = 1'b0;
    repeat (5) tick();
    check("press_early_led", 32'(mode_led), 32'(0));
    tick();
    check("press_led", 32'(mode_led), 32'(1));
    check("press_run_en", 32'(run_en), 32'(0));
    set_cur(6'd7, 6'd31);
    tick();
    check("hold_disp", 32'({disp_hours, disp_minutes}), 32'({6'd7, 6'd30}));
    repeat (3) tick();
    key_mode_n = 1'b1;
    repeat (8) tick();
    press(0, 8);
    check("setmin_led", 32'(mode_led), 32'(2));
    load_exp.push_back({6'd7, 6'd30});
    press(0, 8);
    check("commit2_led", 32'(mode_led), 32'(0));

    // 3: wrap boundaries and simultaneous up+down
    set_cur(6'd23, 6'd59);
    press(0, 8);
    check("w_enter_disp", 32'({disp_hours, disp_minutes}), 32'({6'd23, 6'd59}));
    disp_exp.push_back({6'd0, 6'd59});  press(1, 8);
    disp_exp.push_back({6'd23, 6'd59}); press(2, 8);
    press(3, 8);
    press(0, 8);
    disp_exp.push_back({6'd23, 6'd0});  press(1, 8);
    disp_exp.push_back({6'd23, 6'd59}); press(2, 8);
    disp_exp.push_back({6'd23, 6'd58}); press(2, 8);
    load_exp.push_back({6'd23, 6'd58});
    set_cur(6'd1, 6'd2);
    press(0, 8);
    check("w_run_disp", 32'({disp_hours, disp_minutes}), 32'({6'd1, 6'd2}));
    check("w_queue", 32'(disp_exp.size()), 32'(0));

    // out-of-range capture
    set_cur(6'd30, 6'd63);
    press(0, 8);
    disp_exp.push_back({6'd0, 6'd63}); press(1, 8);
    press(0, 8);
    disp_exp.push_back({6'd0, 6'd59}); press(2, 8);
    load_exp.push_back({6'd0, 6'd59});
    press(0, 8);

    // 4: full edit with commit timing
    set_cur(6'd10, 6'd15);
    press(0, 8);
    disp_exp.push_back({6'd11, 6'd15}); press(1, 8);
    disp_exp.push_back({6'd12, 6'd15}); press(1, 8);
    press(0, 8);
    disp_exp.push_back({6'd12, 6'd14}); press(2, 8);
    load_exp.push_back({6'd12, 6'd14});
    key_mode_n = 1'b0;
    repeat (5) tick();
    check("c_pre_load", 32'(load), 32'(0));
    tick();
    check("c_load", 32'(load), 32'(1));
    check("c_load_run_en", 32'(run_en), 32'(0));
    tick();
    check("c_post_load", 32'(load), 32'(0));
    check("c_post_run_en", 32'(run_en), 32'(1));
    check("c_post_led", 32'(mode_led), 32'(0));
    key_mode_n = 1'b1;
    repeat (8) tick();
    check("c_queue", 32'(load_exp.size()), 32'(0));

    // 5: auto-repeat and blink in SET_MINUTES
    set_cur(6'd10, 6'd20);
    press(0, 8);
    press(0, 8);
    check("r_led", 32'(mode_led), 32'(2));
    for (int v = 21; v <= 24; v++) disp_exp.push_back({6'd10, 6'(v)});
    key_up_n = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      int last;
      tick();
      if (k >= 6) begin
        last = (k >= 36) ? 36 : (k >= 31) ? 31 : (k >= 26) ? 26 : 6;
        check("r_blank", 32'(blank_hex),
              (((k - last) / 8) % 2 == 1) ? 32'(BLANK_MINUTES) : 32'(0));
      end
      if (k == 38) key_up_n = 1'b1;
    end
    check("r_queue", 32'(disp_exp.size()), 32'(0));
    check("r_final", 32'({disp_hours, disp_minutes}), 32'({6'd10, 6'd24}));
    load_exp.push_back({6'd10, 6'd24});
    press(0, 8);

    // 6a: inactivity timeout aborts without load
    set_cur(6'd5, 6'd5);
    press(0, 8);
    disp_exp.push_back({6'd6, 6'd5});
    press(1, 8);
    repeat (185) tick();
    check("t_before_led", 32'(mode_led), 32'(1));
    repeat (10) tick();
    check("t_after_led", 32'(mode_led), 32'(0));
    check("t_run_en", 32'(run_en), 32'(1));
    check("t_disp", 32'({disp_hours, disp_minutes}), 32'({6'd5, 6'd5}));

    // 6b: reset mid-edit
    set_cur(6'd8, 6'd40);
    press(0, 8);
    press(0, 8);
    check("rm_led_pre", 32'(mode_led), 32'(2));
    RESET_N = 1'b0;
    #1;
    check("rm_led", 32'(mode_led), 32'(0));
    check("rm_run_en", 32'(run_en), 32'(1));
    check("rm_load", 32'(load), 32'(0));
    check("rm_blank", 32'(blank_hex), 32'(0));
    repeat (2) tick();
    RESET_N = 1'b1;
    repeat (3) tick();
    check("rm_disp", 32'({disp_hours, disp_minutes}), 32'({6'd8, 6'd40}));

    check("end_disp_queue", 32'(disp_exp.size()), 32'(0));
    check("end_load_queue", 32'(load_exp.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
